// File: rtl/decoder_serial_rx.sv
// Serial receiver feeding the decoder: synchronizes three async pad signals,
// deserializes WIDTH-bit code words and holds each under valid/ready.
// Optional even-parity trailer bit enabled by defining DEC_SERIAL_RX_PARITY_EN.
module decoder_serial_rx #(
  parameter int WIDTH       = 7,
  parameter int SYNC_STAGES = 2,
  parameter int MSB_FIRST   = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ser_clk_i,
  input  logic             ser_data_i,
  input  logic             frame_n_i,
  input  logic             code_ready_i,
  output logic [WIDTH-1:0] code_o,
  output logic             code_valid_o,
  output logic             frame_err_o,
  output logic             overrun_o,
  output logic             parity_err_o
);

`ifdef DEC_SERIAL_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam logic [3:0] DATA_BITS  = 4'(WIDTH);
  localparam logic [3:0] FRAME_BITS = 4'(WIDTH + PAR_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EVAL  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] fr_sync_r, sck_sync_r, dat_sync_r;
  logic                   fr_dly_r, sck_dly_r, dat_dly_r;
  logic                   fr_rise_r, fr_fall_r, sck_rise_r;

  state_t                 state_r, state_nxt_s;
  logic [WIDTH-1:0]       shift_r, shift_nxt_s;
  logic [3:0]             count_r, count_nxt_s;
  logic [WIDTH-1:0]       code_r, code_nxt_s;
  logic                   valid_r, valid_nxt_s;
  logic                   frame_err_r, frame_err_nxt_s;
  logic                   overrun_r, overrun_nxt_s;
  logic                   take_bit_s, count_ok_s, parity_ok_s;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr, input logic b);
    if (MSB_FIRST != 0) begin
      shift_in = {sr[WIDTH-2:0], b};
    end else begin
      shift_in = {b, sr[WIDTH-1:1]};
    end
  endfunction

  // Pad synchronizers, delay flops and registered edge pulses; dat_dly_r is aligned with sck_rise_r.
  // Idle-high ser_clk and low frame_n reset values suppress edges right after reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fr_sync_r  <= {SYNC_STAGES{1'b0}};
      sck_sync_r <= {SYNC_STAGES{1'b1}};
      dat_sync_r <= {SYNC_STAGES{1'b0}};
      fr_dly_r   <= 1'b0;
      sck_dly_r  <= 1'b1;
      dat_dly_r  <= 1'b0;
      fr_rise_r  <= 1'b0;
      fr_fall_r  <= 1'b0;
      sck_rise_r <= 1'b0;
    end else begin
      fr_sync_r  <= {fr_sync_r[SYNC_STAGES-2:0], frame_n_i};
      sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], ser_clk_i};
      dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], ser_data_i};
      fr_dly_r   <= fr_sync_r[SYNC_STAGES-1];
      sck_dly_r  <= sck_sync_r[SYNC_STAGES-1];
      dat_dly_r  <= dat_sync_r[SYNC_STAGES-1];
      fr_rise_r  <= fr_sync_r[SYNC_STAGES-1] & ~fr_dly_r;
      fr_fall_r  <= ~fr_sync_r[SYNC_STAGES-1] & fr_dly_r;
      sck_rise_r <= sck_sync_r[SYNC_STAGES-1] & ~sck_dly_r;
    end
  end

  // A bit coinciding with the frame end is dropped.
  assign take_bit_s = (state_r == SHIFT) && sck_rise_r && !fr_rise_r;
  assign count_ok_s = (count_r == FRAME_BITS);

`ifdef DEC_SERIAL_RX_PARITY_EN
  logic par_bit_r;
  logic parity_err_r;

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    even_parity = ^d;
  endfunction

  assign parity_ok_s = (par_bit_r == even_parity(shift_r));

  // Trailer bit capture and parity error pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      par_bit_r    <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      if (take_bit_s && (count_r == DATA_BITS)) begin
        par_bit_r <= dat_dly_r;
      end
      parity_err_r <= (state_r == EVAL) && count_ok_s && !parity_ok_s;
    end
  end

  assign parity_err_o = parity_err_r;
`else
  assign parity_ok_s  = 1'b1;
  assign parity_err_o = 1'b0;
`endif

  // Next-state, datapath and handshake logic.
  always_comb begin
    state_nxt_s     = state_r;
    shift_nxt_s     = shift_r;
    count_nxt_s     = count_r;
    code_nxt_s      = code_r;
    frame_err_nxt_s = 1'b0;
    overrun_nxt_s   = 1'b0;
    if (valid_r && code_ready_i) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end
    case (state_r)
      IDLE: begin
        if (fr_fall_r) begin
          state_nxt_s = SHIFT;
          shift_nxt_s = {WIDTH{1'b0}};
          count_nxt_s = 4'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (fr_rise_r) begin
          state_nxt_s = EVAL;
        end else if (take_bit_s) begin
          if (count_r != 4'd15) begin
            count_nxt_s = count_r + 4'd1;
          end else begin
            count_nxt_s = count_r;
          end
          // Bits beyond the data width never reach the word register.
          if (count_r < DATA_BITS) begin
            shift_nxt_s = shift_in(shift_r, dat_dly_r);
          end else begin
            shift_nxt_s = shift_r;
          end
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      EVAL: begin
        state_nxt_s = IDLE;
        if (!count_ok_s) begin
          frame_err_nxt_s = 1'b1;
        end else if (!parity_ok_s) begin
          frame_err_nxt_s = 1'b0;
        end else if (!valid_r || code_ready_i) begin
          code_nxt_s  = shift_r;
          valid_nxt_s = 1'b1;
        end else begin
          overrun_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      shift_r     <= {WIDTH{1'b0}};
      count_r     <= 4'd0;
      code_r      <= {WIDTH{1'b0}};
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      shift_r     <= shift_nxt_s;
      count_r     <= count_nxt_s;
      code_r      <= code_nxt_s;
      valid_r     <= valid_nxt_s;
      frame_err_r <= frame_err_nxt_s;
      overrun_r   <= overrun_nxt_s;
    end
  end

  assign code_o       = code_r;
  assign code_valid_o = valid_r;
  assign frame_err_o  = frame_err_r;
  assign overrun_o    = overrun_r;

endmodule

// File: tb/tb_decoder_serial_rx.sv
// Scoreboard bench for decoder_serial_rx: expected words are queued as frames
// are sent and compared when the decoder side accepts them.
module tb_decoder_serial_rx;
  localparam int W    = 7;
  localparam int SYNC = 2;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         ser_clk_i = 1'b0;
  logic         ser_data_i = 1'b0;
  logic         frame_n_i = 1'b1;
  logic         code_ready_i = 1'b0;
  logic [W-1:0] code_o;
  logic         code_valid_o, frame_err_o, overrun_o, parity_err_o;

  int n_chk = 0, n_fail = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int exp_pe = 0;
  logic [W-1:0] exp_q[$];

  decoder_serial_rx #(.WIDTH(W), .SYNC_STAGES(SYNC), .MSB_FIRST(1)) dut (
    .clock(clock), .reset_n(reset_n), .ser_clk_i(ser_clk_i), .ser_data_i(ser_data_i),
    .frame_n_i(frame_n_i), .code_ready_i(code_ready_i), .code_o(code_o),
    .code_valid_o(code_valid_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o),
    .parity_err_o(parity_err_o)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic send_bits(input int n, input logic [15:0] b);
    frame_n_i = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < n; i++) begin
      ser_data_i = b[i];
      repeat (3) tick();
      ser_clk_i = 1'b1;
      repeat (3) tick();
      ser_clk_i = 1'b0;
      repeat (3) tick();
    end
    frame_n_i = 1'b1;
  endtask

  // First bit on the wire is the word MSB; parity trailer when enabled.
  task automatic send_word(input logic [W-1:0] w);
    logic [15:0] b;
    b = 16'h0000;
    for (int i = 0; i < W; i++) b[i] = w[W-1-i];
`ifdef DEC_SERIAL_RX_PARITY_EN
    b[W] = ^w;
    send_bits(W + 1, b);
`else
    send_bits(W, b);
`endif
  endtask

`ifdef DEC_SERIAL_RX_PARITY_EN
  task automatic send_bad_parity(input logic [W-1:0] w);
    logic [15:0] b;
    b = 16'h0000;
    for (int i = 0; i < W; i++) b[i] = w[W-1-i];
    b[W] = ~(^w);
    send_bits(W + 1, b);
  endtask
`endif

  task automatic settle();
    repeat (SYNC + 6) tick();
  endtask

  task automatic accept(input string tag);
    int t;
    t = 0;
    while (!code_valid_o && t < 40) begin
      tick();
      t++;
    end
    check_eq({tag, " valid before accept"}, code_valid_o, 1);
    code_ready_i = 1'b1;
    tick();
    code_ready_i = 1'b0;
    check_eq({tag, " valid after accept"}, code_valid_o, 0);
  endtask

  // Decoder-side monitor: pops on acceptance and tallies pulses.
  always @(negedge clock) begin
    if (reset_n) begin
      if (code_valid_o && code_ready_i) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected word", {25'd0, code_o}, 32'hFFFF_FFFF);
        end else begin
          check_eq("accepted word", code_o, exp_q.pop_front());
        end
      end
      fe_cnt += int'(frame_err_o);
      ov_cnt += int'(overrun_o);
      pe_cnt += int'(parity_err_o);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check_eq("reset code_o", code_o, 0);
    check_eq("reset valid", code_valid_o, 0);
    check_eq("reset pulses", {frame_err_o, overrun_o, parity_err_o}, 0);
    reset_n = 1'b1;
    repeat (6) tick();
    check_eq("no spurious after reset", {code_valid_o, frame_err_o}, 0);

    // Short and long frames are framing errors.
    send_bits(6, 16'h002D);
    settle();
    send_bits(9, 16'h01FF);
    settle();
    check_eq("frame_err count", fe_cnt, 2);
    check_eq("valid after bad frames", code_valid_o, 0);
    check_eq("code after bad frames", code_o, 0);

    // Bits 1,1,0,1,1,0,1 with exact latency from frame end.
    exp_q.push_back(7'h6D);
    send_word(7'h6D);
    repeat (SYNC + 2) tick();
    check_eq("valid one cycle early", code_valid_o, 0);
    tick();
    check_eq("valid at latency", code_valid_o, 1);
    check_eq("code at latency", code_o, 7'h6D);
    repeat (5) tick();
    check_eq("valid held", code_valid_o, 1);
    accept("first");

    // Overrun: pending word survives a second frame.
    exp_q.push_back(7'h6D);
    send_word(7'h6D);
    settle();
    send_word(7'h12);
    settle();
    check_eq("overrun count", ov_cnt, 1);
    check_eq("code held on overrun", code_o, 7'h6D);
    accept("overrun");

    // Accept in the exact load cycle of the next word.
    exp_q.push_back(7'h6D);
    exp_q.push_back(7'h12);
    send_word(7'h6D);
    settle();
    send_word(7'h12);
    repeat (SYNC + 2) tick();
    code_ready_i = 1'b1;
    tick();
    code_ready_i = 1'b0;
    check_eq("valid continuous", code_valid_o, 1);
    check_eq("code after coincident load", code_o, 7'h12);
    check_eq("no overrun on coincident", ov_cnt, 1);
    accept("coincident");

    // Reset in the middle of a frame.
    frame_n_i = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      ser_data_i = 1'b1;
      repeat (3) tick();
      ser_clk_i = 1'b1;
      repeat (3) tick();
      ser_clk_i = 1'b0;
      repeat (3) tick();
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    frame_n_i = 1'b1;
    settle();
    check_eq("code cleared by reset", code_o, 0);
    check_eq("valid cleared by reset", code_valid_o, 0);
    exp_q.push_back(7'h55);
    send_word(7'h55);
    settle();
    check_eq("code after reset frame", code_o, 7'h55);
    accept("post reset");

`ifdef DEC_SERIAL_RX_PARITY_EN
    send_bad_parity(7'h6D);
    settle();
    exp_pe = 1;
    check_eq("valid after parity error", code_valid_o, 0);
`endif

    check_eq("final frame_err count", fe_cnt, 2);
    check_eq("final overrun count", ov_cnt, 1);
    check_eq("final parity_err count", pe_cnt, exp_pe);
    check_eq("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
